video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 288, active pixels per line.
REQ-002 SHALL have parameter H_FP, 20, H front porch in pixels (≥8).
REQ-003 SHALL have parameter H_SYNC, 32, H sync width in pixels (≥1).
REQ-004 SHALL have parameter H_BP, 44, H back porch in pixels (≥8).
REQ-005 SHALL have parameters V_ACTIVE, 224; V_FP, 11 (≥8); V_SYNC, 8 (≥1); V_BP, 21 (≥8); all in lines.
REQ-006 SHALL have parameter RGB_W, 12, pixel data width.
REQ-007 SHALL have parameters HS_POL and VS_POL, 0, sync active level (0 = active-low).
REQ-008 SHALL have port MCLK, input, 1, system clock; the single clock.
REQ-009 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port CE, input, 1, pixel enable; all state advances only on MCLK edges with CE=1.
REQ-011 SHALL have port iRGB, input, RGB_W, pixel from core.
REQ-012 SHALL have ports HSHIFT and VSHIFT, input, 4 each, signed two's-complement screen shift.
REQ-013 SHALL have ports HPOS and VPOS, output, 9 each, current pixel/line counters.
REQ-014 SHALL have ports HBLK, VBLK, HSYN, VSYN, output, 1 each.
REQ-015 SHALL have port oRGB, output, RGB_W, blank-gated pixel.
REQ-016 SHALL have port FSTART, output, 1, frame-start pulse.

Function
REQ-017 SHALL count HPOS 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP), wrapping to 0; VPOS SHALL increment on each HPOS wrap, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-018 SHALL register HBLK = (HPOS ≥ H_ACTIVE) and VBLK = (VPOS ≥ V_ACTIVE), decoded from the next counter value so they align with HPOS/VPOS in the same cycle.
REQ-019 SHALL drive HSYN at active level when HPOS is in [H_ACTIVE+H_FP+hs, H_ACTIVE+H_FP+H_SYNC+hs), where hs is the latched H shift.
REQ-020 SHALL drive VSYN at active level when VPOS is in [V_ACTIVE+V_FP+vs, V_ACTIVE+V_FP+V_SYNC+vs), where vs is the latched V shift; VSYN edges SHALL coincide with the HPOS wrap.
REQ-021 SHALL, on each CE, load oRGB with 0 if HBLK|VBLK is currently asserted, else with iRGB; oRGB therefore lags HPOS by one CE.
REQ-022 SHALL assert FSTART for exactly one MCLK cycle, on the cycle where the counters wrap to (0,0).
REQ-023 SHALL hold all outputs and counters unchanged while CE=0.
REQ-024 SHALL latch HSHIFT/VSHIFT into hs/vs only on the (0,0) wrap cycle; mid-frame changes SHALL NOT affect the current frame.
REQ-025 SHALL require H_TOTAL ≤ 512 and V_TOTAL ≤ 512; an elaboration error SHALL be raised otherwise.

Reset
REQ-026 SHALL, on RESET_N=0 (asynchronous), set HPOS=0, VPOS=0, hs=vs=0, HBLK=0, VBLK=0, HSYN and VSYN inactive, oRGB=0, FSTART=0.
REQ-027 SHALL, after reset release mid-frame, restart at (0,0) on the first CE without emitting FSTART for that CE.

Configuration
REQ-028 SHALL implement screen shift only when macro VTG_SCREEN_SHIFT_EN is defined; REQ-019/020/024 then apply with hs, vs in −8..+7.
REQ-029 SHALL, when VTG_SCREEN_SHIFT_EN is undefined, keep the HSHIFT/VSHIFT ports, ignore them, and fix hs = vs = 0.

Verification
REQ-030 Defaults, CE every 8th MCLK, 2 frames -> HPOS wraps at 383, VPOS at 263, exactly 384×264 CEs per frame, and one FSTART per frame.
REQ-031 Defaults -> HBLK rises at HPOS=288; HSYN is low for HPOS 308..339; VBLK rises at VPOS=224; VSYN is low for VPOS 235..242.
REQ-032 iRGB=12'hFFF constant -> oRGB = FFF exactly for HPOS 1..288 (one-CE lag) on active lines, and 0 elsewhere.
REQ-033 With VTG_SCREEN_SHIFT_EN: HSHIFT=4'h8 set at VPOS=100 -> current frame unchanged; the next frame has HSYN low for HPOS 300..331. Without the macro: HSYN stays at 308..339.
REQ-034 RESET_N pulsed low at HPOS=150, VPOS=50 -> all outputs reach reset values immediately; counting restarts at (0,0); no spurious FSTART.
REQ-035 HS_POL=1, VS_POL=1 -> sync pulses are inverted and reset-idle levels are low.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen -- raster timing generator with blank-gated pixel output.
//
// Counts pixels (HPOS) and lines (VPOS) on every MCLK edge with CE=1. It also
// produces registered blanking and sync strobes aligned with the counters,
// a blank-gated copy of the incoming pixel (one CE behind HPOS), and a
// one-MCLK frame-start pulse on the wrap to (0,0).
//
// Optional feature: define VTG_SCREEN_SHIFT_EN to let HSHIFT/VSHIFT move the
// sync pulses by -8..+7 pixels/lines. The shift is sampled once per frame.
// Without the macro the shift ports are present but ignored.
//
// Ports
//   MCLK    in   system clock (single clock domain)
//   RESET_N in   asynchronous active-low reset
//   CE      in   pixel enable; all state advances only when CE=1
//   iRGB    in   [RGB_W] pixel from the core
//   HSHIFT  in   [4] signed horizontal screen shift
//   VSHIFT  in   [4] signed vertical screen shift
//   HPOS    out  [9] pixel counter, 0..H_TOTAL-1
//   VPOS    out  [9] line counter, 0..V_TOTAL-1
//   HBLK    out  horizontal blank (HPOS >= H_ACTIVE)
//   VBLK    out  vertical blank (VPOS >= V_ACTIVE)
//   HSYN    out  horizontal sync, active level HS_POL
//   VSYN    out  vertical sync, active level VS_POL
//   oRGB    out  [RGB_W] pixel, forced to 0 while blanked
//   FSTART  out  one-MCLK pulse when the counters wrap to (0,0)
module video_timing_gen #(
  parameter int H_ACTIVE = 288,
  parameter int H_FP     = 20,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 44,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 11,
  parameter int V_SYNC   = 8,
  parameter int V_BP     = 21,
  parameter int RGB_W    = 12,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic             MCLK,
  input  logic             RESET_N,
  input  logic             CE,
  input  logic [RGB_W-1:0] iRGB,
  input  logic [3:0]       HSHIFT,
  input  logic [3:0]       VSHIFT,
  output logic [8:0]       HPOS,
  output logic [8:0]       VPOS,
  output logic             HBLK,
  output logic             VBLK,
  output logic             HSYN,
  output logic             VSYN,
  output logic [RGB_W-1:0] oRGB,
  output logic             FSTART
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  // The counters are 9 bits wide, and the porches must absorb a -8..+7
  // shift without the sync pulse leaving the blanking interval.
  if (H_TOTAL > 512) begin : g_h_total_chk
    $error("video_timing_gen: H_TOTAL=%0d exceeds 512", H_TOTAL);
  end
  if (V_TOTAL > 512) begin : g_v_total_chk
    $error("video_timing_gen: V_TOTAL=%0d exceeds 512", V_TOTAL);
  end
  if (H_FP < 8 || H_BP < 8 || H_SYNC < 1) begin : g_h_porch_chk
    $error("video_timing_gen: H_FP/H_BP must be >= 8 and H_SYNC >= 1");
  end
  if (V_FP < 8 || V_BP < 8 || V_SYNC < 1) begin : g_v_porch_chk
    $error("video_timing_gen: V_FP/V_BP must be >= 8 and V_SYNC >= 1");
  end

  // Cleared by reset. The first CE after reset re-enters (0,0) instead of
  // advancing, so a reset in the middle of a frame restarts cleanly and
  // raises no FSTART for that CE.
  logic primed;

  logic [8:0]        h_nxt;
  logic [8:0]        v_nxt;
  logic              h_wrap;
  logic              v_wrap;
  logic              frame_wrap;  // real wrap to (0,0): drives FSTART
  logic              frame_load;  // any entry to (0,0): samples the shift
  logic signed [3:0] hs_nxt;
  logic signed [3:0] vs_nxt;
  logic              hblk_nxt;
  logic              vblk_nxt;
  logic              hsyn_hit;
  logic              vsyn_hit;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so
    // no path can leave one unassigned and infer a latch.
    h_wrap     = (HPOS == H_LAST);
    v_wrap     = (VPOS == V_LAST);
    frame_wrap = primed && h_wrap && v_wrap;
    frame_load = !primed || (h_wrap && v_wrap);
    h_nxt      = '0;
    v_nxt      = '0;
    if (primed) begin
      h_nxt = h_wrap ? '0 : HPOS + 9'd1;
      v_nxt = VPOS;
      if (h_wrap) begin
        v_nxt = v_wrap ? '0 : VPOS + 9'd1;
      end
    end
  end

`ifdef VTG_SCREEN_SHIFT_EN
  logic signed [3:0] hs;
  logic signed [3:0] vs;

  // The shift is sampled only when the counters enter (0,0). A change in
  // the middle of a frame therefore affects the next frame only.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hs <= '0;
      vs <= '0;
    end else if (CE && frame_load) begin
      hs <= $signed(HSHIFT);
      vs <= $signed(VSHIFT);
    end
  end

  assign hs_nxt = frame_load ? $signed(HSHIFT) : hs;
  assign vs_nxt = frame_load ? $signed(VSHIFT) : vs;
`else
  logic unused_shift;

  assign hs_nxt       = '0;
  assign vs_nxt       = '0;
  assign unused_shift = ^{HSHIFT, VSHIFT, frame_load};
`endif

  // Blanking and sync are decoded from the next counter value. They are
  // registered in the same edge as the counters, so they line up with
  // HPOS/VPOS. The comparisons use signed int so that a negative shift
  // works correctly.
  always_comb begin
    hblk_nxt = int'(h_nxt) >= H_ACTIVE;
    vblk_nxt = int'(v_nxt) >= V_ACTIVE;
    hsyn_hit = (int'(h_nxt) >= H_ACTIVE + H_FP + int'(hs_nxt)) &&
               (int'(h_nxt) <  H_ACTIVE + H_FP + H_SYNC + int'(hs_nxt));
    vsyn_hit = (int'(v_nxt) >= V_ACTIVE + V_FP + int'(vs_nxt)) &&
               (int'(v_nxt) <  V_ACTIVE + V_FP + V_SYNC + int'(vs_nxt));
  end

  // NOTE: state registers use non-blocking assignments. All of them then
  // update together at the edge, whatever order they are written in.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      primed <= 1'b0;
      HPOS   <= '0;
      VPOS   <= '0;
      HBLK   <= 1'b0;
      VBLK   <= 1'b0;
      HSYN   <= ~HS_POL;
      VSYN   <= ~VS_POL;
      oRGB   <= '0;
      FSTART <= 1'b0;
    end else begin
      // FSTART is a pulse and is rewritten on every MCLK edge, so it lasts
      // exactly one MCLK even when CE is sparse.
      FSTART <= CE && frame_wrap;
      if (CE) begin
        primed <= 1'b1;
        HPOS   <= h_nxt;
        VPOS   <= v_nxt;
        HBLK   <= hblk_nxt;
        VBLK   <= vblk_nxt;
        HSYN   <= hsyn_hit ? HS_POL : ~HS_POL;
        VSYN   <= vsyn_hit ? VS_POL : ~VS_POL;
        // Gated by the blanking of the position now on the outputs, so the
        // pixel appears one CE behind HPOS.
        oRGB   <= (HBLK || VBLK) ? '0 : iRGB;
      end
    end
  end

endmodule
